// File: rtl/nr_div_scheduler.sv
// Round-robin scheduler wrapped around a shared non-restoring divider, one iteration per clock.
// Optional build macro DIV_ZERO_DET_EN: short-circuit divide-by-zero and raise div_err.
module nr_div_scheduler #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] dividend0,
  input  logic [N-1:0] divisor0,
  input  logic [N-1:0] dividend1,
  input  logic [N-1:0] divisor1,
  output logic [1:0]   out_valid,
  input  logic [1:0]   out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         div_err
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t         state_q, state_d;
  logic [2*N:0]   acc_q, acc_d;
  logic [N:0]     m_q, m_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rr_ptr_q, rr_ptr_d;
  logic           owner_q, owner_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;

  logic           grant_vld, grant, zero_skip;
  logic [N-1:0]   sel_dividend, sel_divisor;
  logic [N:0]     upper_step, upper_fix;
  logic [2*N:0]   acc_iter;

  // Requester at rr_ptr wins when valid, otherwise the other one.
  assign grant_vld    = |req_valid;
  assign grant        = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
  assign sel_dividend = grant ? dividend1 : dividend0;
  assign sel_divisor  = grant ? divisor1  : divisor0;

  // Add/subtract choice follows the sign of the partial remainder before the shift.
  assign upper_step = acc_q[2*N] ? (acc_q[2*N-1:N-1] + m_q) : (acc_q[2*N-1:N-1] - m_q);
  assign acc_iter   = {upper_step, acc_q[N-2:0], ~upper_step[N]};
  assign upper_fix  = acc_q[2*N] ? (acc_q[2*N:N] + m_q) : acc_q[2*N:N];

`ifdef DIV_ZERO_DET_EN
  logic err_q;

  assign zero_skip = (sel_divisor == '0);

  always_ff @(posedge clk) begin
    if (rst)                                        err_q <= 1'b0;
    else if (state_q == IDLE && grant_vld && zero_skip) err_q <= 1'b1;
    else if (state_d == IDLE)                       err_q <= 1'b0;
  end

  assign div_err = err_q;
`else
  assign zero_skip = 1'b0;
  assign div_err   = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    req_ready = 2'b00;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready = grant ? 2'b10 : 2'b01;
          owner_d   = grant;
          rr_ptr_d  = ~grant;
          cnt_d     = '0;
          acc_d     = {{(N+1){1'b0}}, sel_dividend};
          m_d       = {1'b0, sel_divisor};
          if (zero_skip) begin
            quot_d  = '1;
            rem_d   = sel_dividend;
            state_d = DONE;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        acc_d = acc_iter;
        if (cnt_q == CW'(N-1)) state_d = FIX;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      FIX: begin
        acc_d   = {upper_fix, acc_q[N-1:0]};
        quot_d  = acc_q[N-1:0];
        rem_d   = upper_fix[N-1:0];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) req_ready = 2'b00;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
    end
  end

  assign out_valid = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state_q != IDLE);
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_nr_div_scheduler.sv
// Bench for nr_div_scheduler (N=4): vector table plus hand sequences for arbitration,
// back-pressure, mid-division reset and divide-by-zero; results checked through a scoreboard.
module tb_nr_div_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, out_valid, out_ready;
  logic [N-1:0] dividend0, divisor0, dividend1, divisor1, quotient, remainder;
  logic         busy, div_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         who;
    logic [N-1:0] q;
    logic [N-1:0] r;
  } exp_t;

  typedef struct {
    int           who;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    int           hold;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  nr_div_scheduler #(.N(N), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .dividend0(dividend0), .divisor0(divisor0),
    .dividend1(dividend1), .divisor1(divisor1),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .div_err(div_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called and returns at a negedge. Drives one request and follows it through to the handshake.
  task automatic transact(input int who, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er, input int hold);
    int       edges;
    int       exp_lat;
    int       exp_err;
    exp_t     e;
    exp_t     got;
    logic [1:0] oh;
    oh = (who == 1) ? 2'b10 : 2'b01;
    exp_lat = N + 1;
    exp_err = 0;
`ifdef DIV_ZERO_DET_EN
    if (b == '0) begin
      exp_lat = 0;
      exp_err = 1;
    end
`endif
    if (who == 1) begin dividend1 = a; divisor1 = b; end
    else          begin dividend0 = a; divisor0 = b; end
    req_valid[who] = 1'b1;
    #1;
    check("req_ready grant", int'(req_ready), int'(oh));
    if (req_ready !== oh) begin
      req_valid[who] = 1'b0;
      @(negedge clk);
      return;
    end
    e.who = oh[1];
    e.q   = eq;
    e.r   = er;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid[who] = 1'b0;
    if (who == 1) begin dividend1 = ~a; divisor1 = ~b; end
    else          begin dividend0 = ~a; divisor0 = ~b; end
    check("busy after accept", int'(busy), 1);
    edges = 0;
    while (out_valid == 2'b00 && edges < 30) begin
      @(negedge clk);
      edges++;
    end
    check("latency", edges, exp_lat);
    if (out_valid == 2'b00) return;
    check("out_valid owner", int'(out_valid), int'(oh));
    got = sb.pop_front();
    check("quotient", int'(quotient), int'(got.q));
    check("remainder", int'(remainder), int'(got.r));
    check("div_err", int'(div_err), exp_err);
    for (int i = 0; i < hold; i++) begin
      out_ready = ~oh;
      @(negedge clk);
      check("hold out_valid", int'(out_valid), int'(oh));
      check("hold quotient", int'(quotient), int'(got.q));
      check("hold remainder", int'(remainder), int'(got.r));
      check("hold req_ready", int'(req_ready), 0);
      check("hold busy", int'(busy), 1);
    end
    out_ready = oh;
    @(posedge clk);
    @(negedge clk);
    out_ready = 2'b00;
    check("released out_valid", int'(out_valid), 0);
    check("released busy", int'(busy), 0);
  endtask

  initial begin
    bit seen_valid;

    vecs[0] = '{0, 4'd13, 4'd3,  4'd4,  4'd1, 0};
    vecs[1] = '{1, 4'd7,  4'd9,  4'd0,  4'd7, 0};
    vecs[2] = '{1, 4'd15, 4'd1,  4'd15, 4'd0, 0};
    vecs[3] = '{0, 4'd0,  4'd7,  4'd0,  4'd0, 0};
    vecs[4] = '{1, 4'd15, 4'd15, 4'd1,  4'd0, 0};
    vecs[5] = '{0, 4'd14, 4'd4,  4'd3,  4'd2, 10};
    vecs[6] = '{0, 4'd15, 4'd2,  4'd7,  4'd1, 0};
    vecs[7] = '{1, 4'd11, 4'd6,  4'd1,  4'd5, 0};
    vecs[8] = '{1, 4'd8,  4'd8,  4'd1,  4'd0, 0};
    vecs[9] = '{0, 4'd5,  4'd11, 4'd0,  4'd5, 0};

    rst = 1'b1;
    req_valid = 2'b00;
    out_ready = 2'b00;
    dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", int'(req_ready), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset busy", int'(busy), 0);
    check("reset div_err", int'(div_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Both requesters at once right after reset: 0 first, then 1, then 0 wins the next pair.
    dividend0 = 4'd12; divisor0 = 4'd5;
    dividend1 = 4'd9;  divisor1 = 4'd2;
    req_valid = 2'b11;
    transact(0, 4'd12, 4'd5, 4'd2, 4'd2, 0);
    transact(1, 4'd9,  4'd2, 4'd4, 4'd1, 0);
    dividend1 = 4'd10; divisor1 = 4'd3;
    req_valid = 2'b11;
    transact(0, 4'd14, 4'd5, 4'd2, 4'd4, 0);
    transact(1, 4'd10, 4'd3, 4'd3, 4'd1, 0);

    foreach (vecs[i])
      transact(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].hold);

    // Divide by zero returns all-ones quotient and the dividend as remainder.
    transact(0, 4'd6, 4'd0, 4'd15, 4'd6, 0);
    transact(1, 4'd9, 4'd0, 4'd15, 4'd9, 0);

    // Reset while the iteration counter sits at 2: operation dropped, arbitration restarted.
    dividend0 = 4'd13; divisor0 = 4'd3;
    req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid reset out_valid", int'(out_valid), 0);
    check("mid reset busy", int'(busy), 0);
    check("mid reset quotient", int'(quotient), 0);
    check("mid reset remainder", int'(remainder), 0);
    check("mid reset div_err", int'(div_err), 0);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid != 2'b00) seen_valid = 1'b1;
    end
    check("no result after reset", int'(seen_valid), 0);
    dividend1 = 4'd9; divisor1 = 4'd2;
    req_valid = 2'b11;
    transact(0, 4'd12, 4'd5, 4'd2, 4'd2, 0);
    transact(1, 4'd9,  4'd2, 4'd4, 4'd1, 0);

    check("scoreboard empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
